mem_stage: RTL and testbench

Memory-access stage of the five-stage pipeline: the consumer of the EX→MEM pipeline register. It takes the effective address and store data computed in EX, performs byte/half/word loads and stores against an internal data memory, and forwards the WB-stage result into store data. Its MEM→WB pipeline register feeds write-back and the forwarding network. Load results are sign/zero-extended here, so WB only selects and writes.

---
 rtl/mem_stage.sv | 172 +++++++++++++++++
 tb/tb_mem_stage.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage. Holds the internal data memory, performs
// byte/half/word loads and stores, forwards WB data into store data, and
// registers the MEM->WB pipeline state.

`ifndef WIDTH_INSTR
`define WIDTH_INSTR 6
`endif
`ifndef WIDTH_T
`define WIDTH_T 3
`endif

module mem_stage #(
    parameter int unsigned DM_AW = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    clr,
    input  logic [`WIDTH_INSTR-1:0] instr_MEM,
    input  logic [31:0]             PC_MEM,
    input  logic [31:0]             aluOut_MEM,
    input  logic [31:0]             memWriteData_MEM,
    input  logic [4:0]              addrRt_MEM,
    input  logic [4:0]              regWriteAddr_MEM,
    input  logic [31:0]             regWriteData_MEM,
    input  logic [`WIDTH_T-1:0]     Tnew_MEM,
    input  logic [4:0]              regaddr_WB,
    input  logic [31:0]             regdata_WB,
    output logic [`WIDTH_INSTR-1:0] instr_WB,
    output logic [31:0]             PC_WB,
    output logic [4:0]              regWriteAddr_WB,
    output logic [31:0]             regWriteData_WB,
    output logic [`WIDTH_T-1:0]     Tnew_WB
);

    // Decoded instruction ids relevant to this stage; anything else passes through.
    typedef enum logic [`WIDTH_INSTR-1:0] {
        I_NOP = `WIDTH_INSTR'(0),
        I_LW  = `WIDTH_INSTR'(1),
        I_LH  = `WIDTH_INSTR'(2),
        I_LHU = `WIDTH_INSTR'(3),
        I_LB  = `WIDTH_INSTR'(4),
        I_LBU = `WIDTH_INSTR'(5),
        I_SW  = `WIDTH_INSTR'(6),
        I_SH  = `WIDTH_INSTR'(7),
        I_SB  = `WIDTH_INSTR'(8)
    } instr_e;

    localparam int unsigned DEPTH = 1 << DM_AW;

    logic [31:0]            mem_q [DEPTH];
    logic [DM_AW-1:0]       widx;
    logic [1:0]             lane;
    logic [31:0]            rd_word;
    logic [31:0]            wdata;
    logic [31:0]            wr_word;
    logic                   is_load;
    logic                   is_store;
    logic [31:0]            load_data;

    logic [`WIDTH_INSTR-1:0] instr_d, instr_q;
    logic [31:0]             pc_d, pc_q;
    logic [4:0]              waddr_d, waddr_q;
    logic [31:0]             wresult_d, wresult_q;
    logic [`WIDTH_T-1:0]     tnew_d, tnew_q;

    // Upper address bits only feed the store trace; the array wraps on them.
    logic unused_addr_bits;
    assign unused_addr_bits = ^aluOut_MEM[31:DM_AW+2];

    assign widx    = aluOut_MEM[DM_AW+1:2];
    assign lane    = aluOut_MEM[1:0];
    assign rd_word = mem_q[widx];

    // Decode load/store class and forward the WB result into store data.
    always_comb begin
        is_load  = (instr_MEM == I_LW) || (instr_MEM == I_LH) || (instr_MEM == I_LHU) ||
                   (instr_MEM == I_LB) || (instr_MEM == I_LBU);
        is_store = (instr_MEM == I_SW) || (instr_MEM == I_SH) || (instr_MEM == I_SB);
        wdata    = ((regaddr_WB == addrRt_MEM) && (regaddr_WB != 5'd0)) ? regdata_WB
                                                                        : memWriteData_MEM;
    end

    // Merge store data into the addressed word (read-modify-write).
    always_comb begin
        wr_word = rd_word;
        case (instr_MEM)
            I_SW: wr_word = wdata;
            I_SH: begin
                if (lane[1]) wr_word[31:16] = wdata[15:0];
                else         wr_word[15:0]  = wdata[15:0];
            end
            I_SB: begin
                case (lane)
                    2'd0:    wr_word[7:0]   = wdata[7:0];
                    2'd1:    wr_word[15:8]  = wdata[7:0];
                    2'd2:    wr_word[23:16] = wdata[7:0];
                    default: wr_word[31:24] = wdata[7:0];
                endcase
            end
            default: wr_word = rd_word;
        endcase
    end

    // Select and extend load data from the addressed word.
    always_comb begin
        logic [15:0] half;
        logic [7:0]  byte_v;
        half   = lane[1] ? rd_word[31:16] : rd_word[15:0];
        byte_v = rd_word[8*lane +: 8];
        case (instr_MEM)
            I_LW:    load_data = rd_word;
            I_LH:    load_data = {{16{half[15]}}, half};
            I_LHU:   load_data = {16'd0, half};
            I_LB:    load_data = {{24{byte_v[7]}}, byte_v};
            I_LBU:   load_data = {24'd0, byte_v};
            default: load_data = '0;
        endcase
    end

    // Data memory: reset clears every word; stores commit unless stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (!stall && is_store) begin
            mem_q[widx] <= wr_word;
`ifndef SYNTHESIS
            $display("@%h: *%h <= %h", PC_MEM, {aluOut_MEM[31:2], 2'b00}, wr_word);
`endif
        end
    end

    // Next-state for the MEM->WB register: reset/clr bubble, stall hold, else capture.
    always_comb begin
        instr_d   = instr_q;
        pc_d      = pc_q;
        waddr_d   = waddr_q;
        wresult_d = wresult_q;
        tnew_d    = tnew_q;
        if (reset || clr) begin
            instr_d   = '0;
            pc_d      = '0;
            waddr_d   = '0;
            wresult_d = '0;
            tnew_d    = '0;
        end else if (!stall) begin
            instr_d   = instr_MEM;
            pc_d      = PC_MEM;
            waddr_d   = regWriteAddr_MEM;
            wresult_d = is_load ? load_data : regWriteData_MEM;
            tnew_d    = (Tnew_MEM != '0) ? (Tnew_MEM - `WIDTH_T'(1)) : '0;
        end
    end

    // MEM->WB pipeline register.
    always_ff @(posedge clk) begin
        instr_q   <= instr_d;
        pc_q      <= pc_d;
        waddr_q   <= waddr_d;
        wresult_q <= wresult_d;
        tnew_q    <= tnew_d;
    end

    assign instr_WB        = instr_q;
    assign PC_WB           = pc_q;
    assign regWriteAddr_WB = waddr_q;
    assign regWriteData_WB = wresult_q;
    assign Tnew_WB         = tnew_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed-vector bench for mem_stage with hand-computed results.

`ifndef WIDTH_INSTR
`define WIDTH_INSTR 6
`endif
`ifndef WIDTH_T
`define WIDTH_T 3
`endif

module tb_mem_stage;

    localparam logic [`WIDTH_INSTR-1:0] OP_ALU = `WIDTH_INSTR'(9);
    localparam logic [`WIDTH_INSTR-1:0] OP_LW  = `WIDTH_INSTR'(1);
    localparam logic [`WIDTH_INSTR-1:0] OP_LH  = `WIDTH_INSTR'(2);
    localparam logic [`WIDTH_INSTR-1:0] OP_LHU = `WIDTH_INSTR'(3);
    localparam logic [`WIDTH_INSTR-1:0] OP_LB  = `WIDTH_INSTR'(4);
    localparam logic [`WIDTH_INSTR-1:0] OP_LBU = `WIDTH_INSTR'(5);
    localparam logic [`WIDTH_INSTR-1:0] OP_SW  = `WIDTH_INSTR'(6);
    localparam logic [`WIDTH_INSTR-1:0] OP_SH  = `WIDTH_INSTR'(7);
    localparam logic [`WIDTH_INSTR-1:0] OP_SB  = `WIDTH_INSTR'(8);

    logic                    clk = 1'b0;
    logic                    reset, stall, clr;
    logic [`WIDTH_INSTR-1:0] instr_MEM;
    logic [31:0]             PC_MEM, aluOut_MEM, memWriteData_MEM, regWriteData_MEM, regdata_WB;
    logic [4:0]              addrRt_MEM, regWriteAddr_MEM, regaddr_WB;
    logic [`WIDTH_T-1:0]     Tnew_MEM;
    logic [`WIDTH_INSTR-1:0] instr_WB;
    logic [31:0]             PC_WB, regWriteData_WB;
    logic [4:0]              regWriteAddr_WB;
    logic [`WIDTH_T-1:0]     Tnew_WB;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_stage #(.DM_AW(10)) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .clr              (clr),
        .instr_MEM        (instr_MEM),
        .PC_MEM           (PC_MEM),
        .aluOut_MEM       (aluOut_MEM),
        .memWriteData_MEM (memWriteData_MEM),
        .addrRt_MEM       (addrRt_MEM),
        .regWriteAddr_MEM (regWriteAddr_MEM),
        .regWriteData_MEM (regWriteData_MEM),
        .Tnew_MEM         (Tnew_MEM),
        .regaddr_WB       (regaddr_WB),
        .regdata_WB       (regdata_WB),
        .instr_WB         (instr_WB),
        .PC_WB            (PC_WB),
        .regWriteAddr_WB  (regWriteAddr_WB),
        .regWriteData_WB  (regWriteData_WB),
        .Tnew_WB          (Tnew_WB)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Present one instruction in MEM, clock it, then settle just past the edge.
    task automatic issue(input logic [`WIDTH_INSTR-1:0] op, input logic [31:0] pc,
                         input logic [31:0] addr, input logic [31:0] sdata);
        instr_MEM        = op;
        PC_MEM           = pc;
        aluOut_MEM       = addr;
        memWriteData_MEM = sdata;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; clr = 1'b0;
        addrRt_MEM = 5'd0; regWriteAddr_MEM = 5'd7; regWriteData_MEM = 32'h5555_AAAA;
        Tnew_MEM = `WIDTH_T'(2); regaddr_WB = 5'd0; regdata_WB = 32'h0;
        #2;
        // Reset with nonzero inputs present: everything must read zero.
        issue(OP_LW, 32'h0000_3000, 32'h0, 32'h0);
        issue(OP_LW, 32'h0000_3000, 32'h0, 32'h0);
        check("rst_instr", 32'(instr_WB), 32'h0);
        check("rst_pc", PC_WB, 32'h0);
        check("rst_waddr", 32'(regWriteAddr_WB), 32'h0);
        check("rst_wdata", regWriteData_WB, 32'h0);
        check("rst_tnew", 32'(Tnew_WB), 32'h0);
        reset = 1'b0;

        issue(OP_LW, 32'h0000_3004, 32'h0, 32'h0);
        check("lw0_after_rst", regWriteData_WB, 32'h0);
        check("lw0_pc", PC_WB, 32'h0000_3004);
        check("lw0_waddr", 32'(regWriteAddr_WB), 32'd7);

        issue(OP_SW, 32'h0000_3008, 32'h100, 32'h1234_5678);
        check("sw_passthru", regWriteData_WB, 32'h5555_AAAA);
        issue(OP_LW, 32'h0000_300C, 32'h100, 32'h0);
        check("lw_100", regWriteData_WB, 32'h1234_5678);
        issue(OP_LB, 32'h0000_3010, 32'h103, 32'h0);
        check("lb_103", regWriteData_WB, 32'h0000_0012);
        issue(OP_LB, 32'h0000_3014, 32'h100, 32'h0);
        check("lb_100", regWriteData_WB, 32'h0000_0078);

        issue(OP_SB, 32'h0000_3018, 32'h101, 32'hFFFF_FF80);
        issue(OP_LW, 32'h0000_301C, 32'h100, 32'h0);
        check("sb_merge", regWriteData_WB, 32'h1234_8078);
        issue(OP_LB, 32'h0000_3020, 32'h101, 32'h0);
        check("lb_sext", regWriteData_WB, 32'hFFFF_FF80);
        issue(OP_LBU, 32'h0000_3024, 32'h101, 32'h0);
        check("lbu_zext", regWriteData_WB, 32'h0000_0080);
        issue(OP_SH, 32'h0000_3028, 32'h102, 32'h1111_BEEF);
        issue(OP_LW, 32'h0000_302C, 32'h100, 32'h0);
        check("sh_merge", regWriteData_WB, 32'hBEEF_8078);
        issue(OP_LH, 32'h0000_3030, 32'h103, 32'h0);
        check("lh_sext", regWriteData_WB, 32'hFFFF_BEEF);
        issue(OP_LHU, 32'h0000_3034, 32'h101, 32'h0);
        check("lhu_low", regWriteData_WB, 32'h0000_8078);

        // WB forwarding into store data.
        addrRt_MEM = 5'd5; regaddr_WB = 5'd5; regdata_WB = 32'hCAFE_BABE;
        issue(OP_SW, 32'h0000_3038, 32'h200, 32'h0);
        regaddr_WB = 5'd0;
        issue(OP_LW, 32'h0000_303C, 32'h200, 32'h0);
        check("fwd_wb", regWriteData_WB, 32'hCAFE_BABE);
        addrRt_MEM = 5'd0; regaddr_WB = 5'd0; regdata_WB = 32'h1357_9BDF;
        issue(OP_SW, 32'h0000_3040, 32'h200, 32'h0);
        issue(OP_LW, 32'h0000_3044, 32'h200, 32'h0);
        check("fwd_r0_none", regWriteData_WB, 32'h0);
        regdata_WB = 32'h0;

        // Stall: store suppressed, register held.
        issue(OP_LW, 32'h0000_3048, 32'h100, 32'h0);
        stall = 1'b1;
        issue(OP_SW, 32'h0000_304C, 32'h300, 32'h1111_1111);
        check("stall_pc", PC_WB, 32'h0000_3048);
        check("stall_data", regWriteData_WB, 32'hBEEF_8078);
        check("stall_instr", 32'(instr_WB), 32'(OP_LW));
        stall = 1'b0;
        issue(OP_LW, 32'h0000_3050, 32'h300, 32'h0);
        check("stall_nowrite", regWriteData_WB, 32'h0);

        // Clear: bubble in WB, store still commits.
        clr = 1'b1;
        issue(OP_SW, 32'h0000_3054, 32'h300, 32'h2222_2222);
        check("clr_instr", 32'(instr_WB), 32'h0);
        check("clr_pc", PC_WB, 32'h0);
        check("clr_data", regWriteData_WB, 32'h0);
        clr = 1'b0;
        issue(OP_LW, 32'h0000_3058, 32'h300, 32'h0);
        check("clr_write", regWriteData_WB, 32'h2222_2222);

        // Address wrap modulo 4 KiB.
        issue(OP_SW, 32'h0000_305C, 32'h1000, 32'hA5A5_A5A5);
        issue(OP_LW, 32'h0000_3060, 32'h0, 32'h0);
        check("wrap", regWriteData_WB, 32'hA5A5_A5A5);

        // Non-memory passthrough and Tnew decrement.
        regWriteAddr_MEM = 5'd12; regWriteData_MEM = 32'hDEAD_0001; Tnew_MEM = `WIDTH_T'(2);
        issue(OP_ALU, 32'h0000_3064, 32'h100, 32'h0);
        check("alu_data", regWriteData_WB, 32'hDEAD_0001);
        check("alu_waddr", 32'(regWriteAddr_WB), 32'd12);
        check("tnew_2", 32'(Tnew_WB), 32'd1);
        Tnew_MEM = `WIDTH_T'(0);
        issue(OP_ALU, 32'h0000_3068, 32'h100, 32'h0);
        check("tnew_0", 32'(Tnew_WB), 32'd0);

        // Reset clears memory and drops a concurrent store.
        reset = 1'b1;
        issue(OP_SW, 32'h0000_306C, 32'h400, 32'h7777_7777);
        reset = 1'b0;
        issue(OP_LW, 32'h0000_3070, 32'h100, 32'h0);
        check("rst_clear", regWriteData_WB, 32'h0);
        issue(OP_LW, 32'h0000_3074, 32'h400, 32'h0);
        check("rst_drop_sw", regWriteData_WB, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
